sprite_vram: RTL and testbench
==============================

SPRITE_VRAM -- requirements
Module: sprite_vram

Interface
REQ-001 SHALL have parameter SPRITE_W, default 16, meaning sprite width in pixels (power of 2).
REQ-002 SHALL have parameter SPRITE_H, default 16, meaning sprite height in pixels (power of 2).
REQ-003 SHALL have parameter PIX_BITS, default 3, meaning colour bits per pixel ({R,G,B} at default).
REQ-004 SHALL have parameter NUM_IMAGES, default 8, meaning number of sprites stored (power of 2); IW = log2(NUM_IMAGES), AW = log2(SPRITE_W*SPRITE_H).
REQ-005 SHALL have parameters CLEAR_COLOR, default all-ones (white), and TRANSP_COLOR, default 3'b110, meaning post-reset fill colour and transparent key.
REQ-006 SHALL have ports: clk in 1 clock; rst_n in 1 asynchronous active-low reset.
REQ-007 SHALL have ports: rd_en in 1 read strobe; rd_addr in AW pixel address (row-major, y*SPRITE_W+x); rd_valid out 1; rd_data out PIX_BITS; rd_opaque out 1 (rd_data != TRANSP_COLOR).
REQ-008 SHALL have ports: wr_valid in 1; wr_ready out 1; wr_image in IW; wr_addr in AW; wr_data in PIX_BITS.
REQ-009 SHALL have ports: frame_tick in 1 (one-cycle pulse per video frame); image_sel in IW; anim_en in 1; anim_first in IW; anim_last in IW; anim_div in 8 (ticks per animation step minus 1).
REQ-010 SHALL have ports: cur_image out IW (image currently displayed); init_done out 1.

Function
REQ-011 Storage SHALL be NUM_IMAGES*SPRITE_W*SPRITE_H words of PIX_BITS, addressed {image, pixel_addr}.
REQ-012 FSM SHALL have states CLEAR and RUN; reset enters CLEAR with clear pointer 0.
REQ-013 In CLEAR, one word SHALL be written with CLEAR_COLOR per cycle, pointer incrementing; after the last word (DEPTH-1) the FSM SHALL go to RUN and assert init_done the next cycle.
REQ-014 In CLEAR, wr_ready SHALL be 0 and rd_data SHALL read CLEAR_COLOR (rd_valid still follows rd_en).
REQ-015 Read latency SHALL be exactly 1 cycle: rd_valid = rd_en delayed one cycle; rd_data/rd_opaque hold the word at {cur_image, rd_addr} sampled at the rd_en cycle; rd_data holds its value while rd_valid=0.
REQ-016 Read SHALL have priority: in RUN, wr_ready = !rd_en; a write completes on wr_valid && wr_ready and is visible to any read issued the following cycle or later.
REQ-017 wr_valid/wr_image/wr_addr/wr_data SHALL be held by the source until wr_ready; no write SHALL be lost or duplicated.
REQ-018 cur_image SHALL change only in the cycle after a frame_tick; reads in the tick cycle use the old cur_image.
REQ-019 anim_en=0: on frame_tick, cur_image <= image_sel; step counter cleared.
REQ-020 anim_en=1: 8-bit step counter increments per frame_tick; when counter == anim_div, counter <= 0 and cur_image advances; anim_div=0 advances every tick.
REQ-021 Advance rule: cur_image == anim_last -> anim_first; cur_image outside [anim_first, anim_last] -> anim_first; else cur_image+1.
REQ-022 anim_first > anim_last SHALL be treated as single-image loop at anim_first.
REQ-023 Animation and manual selection SHALL operate identically in CLEAR and RUN.

Reset
REQ-024 On rst_n low: FSM=CLEAR, clear pointer 0, init_done 0, wr_ready 0, rd_valid 0, rd_data CLEAR_COLOR, rd_opaque (CLEAR_COLOR != TRANSP_COLOR), cur_image 0, step counter 0.
REQ-025 Reset asserted mid-operation SHALL abort any in-flight read/write and restart the full clear.

Structure
REQ-026 Shared package SHALL hold the FSM state typedef and default SPRITE_W/SPRITE_H/PIX_BITS/NUM_IMAGES/colour constants.
REQ-027 One sub-module sprite_vram_ram (simple dual-port, sync read, 1 write port, no reset) SHALL hold storage; controller, animator, and read pipeline live in sprite_vram.

Verification
REQ-028 Reset, wait: init_done rises exactly DEPTH+1 cycles (2049 at default) after rst_n release; every address reads 3'b111, rd_opaque=1.
REQ-029 After init, write image 2 addr 0x15 = 3'b000, image_sel=2, frame_tick, read 0x15 -> rd_data 3'b000 one cycle after rd_en; image 3 addr 0x15 still 3'b111.
REQ-030 Hold wr_valid with rd_en high 5 cycles: wr_ready=0 throughout, write completes first cycle rd_en drops, exactly once.
REQ-031 anim_en=1, first=1, last=3, div=2, cur_image=0: 12 ticks -> cur_image sequence 1,2,3,1 changing on ticks 3,6,9,12.
REQ-032 Write TRANSP_COLOR 3'b110 and read it: rd_opaque=0; read a 3'b111 pixel: rd_opaque=1.
REQ-033 Assert rst_n low mid-animation with pending write: all outputs at reset values, write not performed, full clear reruns.

Source files
------------

// File: rtl/sprite_vram_pkg.sv
// Shared types and default geometry/colour constants for the sprite VRAM.
package sprite_vram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int DEF_SPRITE_W   = 16;
  localparam int DEF_SPRITE_H   = 16;
  localparam int DEF_PIX_BITS   = 3;
  localparam int DEF_NUM_IMAGES = 8;
  localparam int STEP_W         = 8;

  localparam logic [2:0] DEF_CLEAR_COLOR  = 3'b111;
  localparam logic [2:0] DEF_TRANSP_COLOR = 3'b110;

endpackage

// File: rtl/sprite_vram_ram.sv
// Simple dual-port pixel store: one synchronous write port, one registered read port.
module sprite_vram_ram #(
  parameter int DATA_W = 3,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: storage and its read register carry no reset so they map onto block RAM;
  // the controller's clear sweep gives the array its defined contents.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sprite_vram.sv
// Sprite image store with post-reset clear, read-priority write port and frame-driven animator.
module sprite_vram
  import sprite_vram_pkg::*;
#(
  parameter int SPRITE_W   = DEF_SPRITE_W,
  parameter int SPRITE_H   = DEF_SPRITE_H,
  parameter int PIX_BITS   = DEF_PIX_BITS,
  parameter int NUM_IMAGES = DEF_NUM_IMAGES,
  parameter logic [PIX_BITS-1:0] CLEAR_COLOR  = {PIX_BITS{1'b1}},
  parameter logic [PIX_BITS-1:0] TRANSP_COLOR = PIX_BITS'(DEF_TRANSP_COLOR),
  localparam int IW = $clog2(NUM_IMAGES),
  localparam int AW = $clog2(SPRITE_W * SPRITE_H)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_addr,
  output logic                rd_valid,
  output logic [PIX_BITS-1:0] rd_data,
  output logic                rd_opaque,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [IW-1:0]       wr_image,
  input  logic [AW-1:0]       wr_addr,
  input  logic [PIX_BITS-1:0] wr_data,
  input  logic                frame_tick,
  input  logic [IW-1:0]       image_sel,
  input  logic                anim_en,
  input  logic [IW-1:0]       anim_first,
  input  logic [IW-1:0]       anim_last,
  input  logic [STEP_W-1:0]   anim_div,
  output logic [IW-1:0]       cur_image,
  output logic                init_done
);

  localparam int              DW       = IW + AW;
  localparam int              DEPTH    = NUM_IMAGES * SPRITE_W * SPRITE_H;
  localparam logic [DW-1:0]   LAST_PTR = DW'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [DW-1:0]       clr_ptr_q, clr_ptr_d;
  logic                init_done_q, rd_valid_q, rd_clear_q;
  logic [IW-1:0]       cur_image_q, cur_image_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                ram_we;
  logic [DW-1:0]       ram_waddr;
  logic [PIX_BITS-1:0] ram_wdata, ram_rdata;

  // A reversed or out-of-range window always restarts at the first frame.
  function automatic logic [IW-1:0] next_image(input logic [IW-1:0] cur,
                                               input logic [IW-1:0] first,
                                               input logic [IW-1:0] last);
    if (first > last || cur == last || cur < first || cur > last) return first;
    return cur + 1'b1;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    wr_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = {wr_image, wr_addr};
    ram_wdata = wr_data;
    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_ptr_q;
        ram_wdata = CLEAR_COLOR;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_PTR) state_d = ST_RUN;
      end
      ST_RUN: begin
        wr_ready = !rd_en;
        ram_we   = wr_valid && !rd_en;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    cur_image_d = cur_image_q;
    step_d      = step_q;
    if (frame_tick) begin
      if (!anim_en) begin
        cur_image_d = image_sel;
        step_d      = '0;
      end else if (step_q == anim_div) begin
        step_d      = '0;
        cur_image_d = next_image(cur_image_q, anim_first, anim_last);
      end else begin
        step_d = step_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clr_ptr_q   <= '0;
      init_done_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_clear_q  <= 1'b1;
      cur_image_q <= '0;
      step_q      <= '0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      init_done_q <= (state_q == ST_RUN);
      rd_valid_q  <= rd_en;
      if (rd_en) rd_clear_q <= (state_q == ST_CLEAR);
      cur_image_q <= cur_image_d;
      step_q      <= step_d;
    end
  end

  sprite_vram_ram #(
    .DATA_W (PIX_BITS),
    .ADDR_W (DW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (rd_en),
    .raddr_i ({cur_image_q, rd_addr}),
    .rdata_o (ram_rdata)
  );

  // Reads issued while clearing (and the state straight out of reset) show the fill colour.
  assign rd_data   = rd_clear_q ? CLEAR_COLOR : ram_rdata;
  assign rd_opaque = (rd_data != TRANSP_COLOR);
  assign rd_valid  = rd_valid_q;
  assign cur_image = cur_image_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_sprite_vram.sv
// Randomised scoreboard bench for sprite_vram against a behavioural image-store model.
module tb_sprite_vram;
  import sprite_vram_pkg::*;

  localparam int IW    = 3;
  localparam int AW    = 8;
  localparam int DEPTH = 2048;
  localparam logic [2:0] CLR    = DEF_CLEAR_COLOR;
  localparam logic [2:0] TRANSP = DEF_TRANSP_COLOR;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_valid;
  logic [2:0]    rd_data;
  logic          rd_opaque;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [IW-1:0] wr_image = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [2:0]    wr_data = '0;
  logic          frame_tick = 1'b0;
  logic [IW-1:0] image_sel = '0;
  logic          anim_en = 1'b0;
  logic [IW-1:0] anim_first = '0;
  logic [IW-1:0] anim_last = '0;
  logic [7:0]    anim_div = '0;
  logic [IW-1:0] cur_image;
  logic          init_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0]    mem_m [DEPTH];
  logic [IW-1:0] cur_m = '0;
  int            step_m = 0;
  bit            run_m = 1'b0;
  logic [2:0]    exp_q [$];
  logic [2:0]    last_rd = 3'b111;
  logic [2:0]    mon_e;

  always #5 clk = ~clk;

  sprite_vram dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_opaque  (rd_opaque),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_image   (wr_image),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_tick (frame_tick),
    .image_sel  (image_sel),
    .anim_en    (anim_en),
    .anim_first (anim_first),
    .anim_last  (anim_last),
    .anim_div   (anim_div),
    .cur_image  (cur_image),
    .init_done  (init_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Animation reference: count ticks, step through [first,last] and wrap.
  task automatic anim_model();
    if (!anim_en) begin
      cur_m  = image_sel;
      step_m = 0;
    end else if (step_m == int'(anim_div)) begin
      step_m = 0;
      if (anim_first > anim_last) cur_m = anim_first;
      else if (cur_m >= anim_first && cur_m < anim_last) cur_m = cur_m + 1'b1;
      else cur_m = anim_first;
    end else begin
      step_m++;
    end
  endtask

  // One clock cycle: inputs are already driven; predict, clock, then check.
  task automatic step(input bit chk_wr);
    bit            fire, rd_now, tick_now;
    logic [10:0]   wa;
    logic [2:0]    wd;
    #1;
    if (chk_wr) check("wr_ready", wr_ready, run_m && !rd_en);
    fire     = run_m && wr_valid && !rd_en;
    rd_now   = rd_en;
    tick_now = frame_tick;
    wa       = {wr_image, wr_addr};
    wd       = wr_data;
    if (rd_en) exp_q.push_back(run_m ? mem_m[{cur_m, rd_addr}] : CLR);
    @(posedge clk);
    if (fire) mem_m[wa] = wd;
    if (tick_now) anim_model();
    #1;
    if (fire) wr_valid = 1'b0;
    frame_tick = 1'b0;
    check("rd_valid", rd_valid, rd_now);
    check("cur_image", cur_image, cur_m);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("rd_unexpected");
        end else begin
          mon_e = exp_q.pop_front();
          check("rd_data", rd_data, mon_e);
          check("rd_opaque", rd_opaque, mon_e != TRANSP);
          last_rd = mon_e;
        end
      end else begin
        check("rd_hold", rd_data, last_rd);
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, CLR);
    check("rst_rd_opaque", rd_opaque, 1);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_init_done", init_done, 0);
    check("rst_cur_image", cur_image, 0);
    exp_q.delete();
    last_rd = CLR;
    run_m   = 1'b0;
    cur_m   = '0;
    step_m  = 0;
    foreach (mem_m[i]) mem_m[i] = CLR;
  endtask

  task automatic run_init();
    int cnt;
    cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    while (!init_done && cnt < 3000) begin
      rd_en      = ($urandom % 2) == 1;
      rd_addr    = AW'($urandom);
      anim_en    = 1'b0;
      image_sel  = IW'($urandom);
      frame_tick = (cnt % 300) == 150;
      step(cnt < 2000);
      cnt++;
    end
    check("init_cycles", cnt, 2049);
    rd_en = 1'b0;
    run_m = 1'b1;
  endtask

  task automatic select_image(input logic [IW-1:0] img);
    anim_en    = 1'b0;
    image_sel  = img;
    frame_tick = 1'b1;
    step(1);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    step(1);
    rd_en = 1'b0;
  endtask

  task automatic do_write(input logic [IW-1:0] img, input logic [AW-1:0] a, input logic [2:0] d);
    wr_valid = 1'b1;
    wr_image = img;
    wr_addr  = a;
    wr_data  = d;
    for (int i = 0; i < 64 && wr_valid; i++) begin
      rd_en   = ($urandom % 4) == 0;
      rd_addr = AW'($urandom);
      step(1);
    end
    rd_en = 1'b0;
    if (wr_valid) begin
      fail_now("wr_timeout");
      wr_valid = 1'b0;
    end
  endtask

  initial begin
    int exp_seq [12];
    exp_seq = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 1};

    #2;
    apply_reset();
    repeat (3) @(posedge clk);
    run_init();

    // Every pixel of every image reads back the fill colour.
    for (int img = 0; img < 8; img++) begin
      select_image(IW'(img));
      for (int a = 0; a < 256; a++) begin
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        step(1);
      end
      rd_en = 1'b0;
    end

    do_write(3'd2, 8'h15, 3'b000);
    select_image(3'd2);
    do_read(8'h15);
    check("img2_write_visible", rd_data, 3'b000);
    select_image(3'd3);
    do_read(8'h15);
    check("img3_untouched", rd_data, 3'b111);

    // Write held off by five back-to-back reads, then accepted once.
    wr_valid = 1'b1;
    wr_image = 3'd5;
    wr_addr  = 8'h40;
    wr_data  = 3'b010;
    for (int i = 0; i < 5; i++) begin
      rd_en   = 1'b1;
      rd_addr = AW'($urandom);
      step(1);
    end
    rd_en = 1'b0;
    step(1);
    select_image(3'd5);
    do_read(8'h40);
    check("held_write_data", rd_data, 3'b010);

    do_write(3'd1, 8'h07, TRANSP);
    select_image(3'd1);
    do_read(8'h07);
    check("transp_opaque", rd_opaque, 0);
    do_read(8'h08);
    check("white_opaque", rd_opaque, 1);

    select_image(3'd0);
    anim_en    = 1'b1;
    anim_first = 3'd1;
    anim_last  = 3'd3;
    anim_div   = 8'd2;
    for (int t = 0; t < 12; t++) begin
      frame_tick = 1'b1;
      step(1);
      check("anim_seq", cur_image, exp_seq[t]);
    end

    for (int c = 0; c < 1500; c++) begin
      if (!wr_valid && ($urandom % 3) == 0) begin
        wr_valid = 1'b1;
        wr_image = IW'($urandom);
        wr_addr  = AW'($urandom_range(0, 15));
        wr_data  = (($urandom % 4) == 0) ? TRANSP : 3'($urandom);
      end
      rd_en   = ($urandom % 2) == 1;
      rd_addr = AW'($urandom_range(0, 15));
      if (($urandom % 8) == 0) begin
        frame_tick = 1'b1;
        anim_en    = ($urandom % 3) != 0;
        image_sel  = IW'($urandom);
        anim_first = IW'($urandom);
        anim_last  = IW'($urandom);
        anim_div   = 8'($urandom_range(0, 2));
      end
      step(1);
    end
    rd_en = 1'b0;
    for (int i = 0; i < 4 && wr_valid; i++) step(1);

    // Reset mid-animation with a write stalled behind a read.
    anim_en    = 1'b1;
    anim_first = 3'd2;
    anim_last  = 3'd6;
    anim_div   = 8'd0;
    for (int i = 0; i < 3; i++) begin
      frame_tick = 1'b1;
      step(1);
    end
    wr_valid = 1'b1;
    wr_image = 3'd4;
    wr_addr  = 8'h33;
    wr_data  = 3'b000;
    rd_en    = 1'b1;
    rd_addr  = 8'h33;
    step(1);
    #1;
    apply_reset();
    repeat (2) @(posedge clk);
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    anim_en  = 1'b0;
    run_init();

    select_image(3'd4);
    do_read(8'h33);
    check("aborted_write_absent", rd_data, 3'b111);
    for (int img = 0; img < 8; img++) begin
      select_image(IW'(img));
      for (int a = 0; a < 16; a++) begin
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        step(1);
      end
      rd_en = 1'b0;
    end

    rd_en = 1'b0;
    repeat (3) step(1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
